// File: rtl/dnn_param_mem.sv
// ============================================================================
// dnn_param_mem: nibble-addressed parameter image for the sigmoid engines,
// filled by a byte-stream loader and read back with a fixed one-cycle latency.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dnn_param_mem #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 16'h29de
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ld_start,
  input  logic                         ld_valid,
  input  logic [2*DATA_WIDTH-1:0]      ld_data,
  output logic                         ld_ready,
  output logic                         loaded,
  output logic                         ld_overflow,
  input  logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic signed [DATA_WIDTH-1:0] mem_data
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WPW = ADDR_WIDTH + 1;
  localparam logic [WPW-1:0] c_depth = WPW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t                  r_state;
  logic [WPW-1:0]          r_wp;
  logic                    r_ld_ready;
  logic                    r_loaded;
  logic                    r_overflow;
  logic [DATA_WIDTH-1:0]   r_q;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic [WPW-1:0]          w_wp1;
  logic [WPW-1:0]          w_wp2;
  logic                    w_wr;
  logic                    w_wr_hi;
  logic                    w_rd_ok;

  assign w_wp1   = r_wp + WPW'(1);
  assign w_wp2   = r_wp + WPW'(2);
  assign w_wr    = ld_valid && r_ld_ready;
  // Upper nibble is dropped when the image has an odd number of words.
  assign w_wr_hi = w_wr && (w_wp1 < c_depth);
  assign w_rd_ok = r_loaded && ({1'b0, mem_addr} < c_depth);

  assign ld_ready    = r_ld_ready;
  assign loaded      = r_loaded;
  assign ld_overflow = r_overflow;
  assign mem_data    = r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_wp       <= '0;
      r_ld_ready <= 1'b0;
      r_loaded   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ld_start) begin
            r_state    <= S_LOAD;
            r_wp       <= '0;
            r_ld_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (ld_valid) begin
            r_wp <= w_wp2;
            if (w_wp2 >= c_depth) begin
              r_state    <= S_READY;
              r_ld_ready <= 1'b0;
              r_loaded   <= 1'b1;
            end
          end
        end
        S_READY: begin
          if (ld_valid) begin
            r_overflow <= 1'b1;
          end
          if (ld_start) begin
            r_state    <= S_LOAD;
            r_wp       <= '0;
            r_ld_ready <= 1'b1;
            r_loaded   <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_ld_ready <= 1'b0;
          r_loaded   <= 1'b0;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; r_loaded gates every read instead.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wp[AW-1:0]] <= ld_data[DATA_WIDTH-1:0];
    end
    if (w_wr_hi) begin
      r_mem[w_wp1[AW-1:0]] <= ld_data[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else begin
      r_q <= w_rd_ok ? r_mem[mem_addr[AW-1:0]] : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dnn_param_mem.sv
// ============================================================================
// tb_dnn_param_mem: table-driven and randomized checks of dnn_param_mem
// using a DEPTH=6 and a DEPTH=5 instance on a shared clock and reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dnn_param_mem;

  logic clk;
  logic rst;

  logic              st   [2];
  logic              v    [2];
  logic [7:0]        dat  [2];
  logic [15:0]       addr [2];
  logic              rdy  [2];
  logic              ld   [2];
  logic              ov   [2];
  logic signed [3:0] q    [2];

  int n_tests = 0;
  int n_fail  = 0;

  dnn_param_mem #(.DATA_WIDTH(4), .ADDR_WIDTH(16), .DEPTH(6)) u_d6 (
    .clk(clk), .rst(rst), .ld_start(st[0]), .ld_valid(v[0]), .ld_data(dat[0]),
    .ld_ready(rdy[0]), .loaded(ld[0]), .ld_overflow(ov[0]),
    .mem_addr(addr[0]), .mem_data(q[0])
  );

  dnn_param_mem #(.DATA_WIDTH(4), .ADDR_WIDTH(16), .DEPTH(5)) u_d5 (
    .clk(clk), .rst(rst), .ld_start(st[1]), .ld_valid(v[1]), .ld_data(dat[1]),
    .ld_ready(rdy[1]), .loaded(ld[1]), .ld_overflow(ov[1]),
    .mem_addr(addr[1]), .mem_data(q[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic            dut;
    logic [2:0]      gaps;
    logic [7:0]      b0;
    logic [7:0]      b1;
    logic [7:0]      b2;
    logic [0:5][3:0] e;
  } vec_t;

  vec_t vecs [4];

  logic signed [3:0] mimg [6];
  bit                mov;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Start pulse, then three bytes; gaps[i] idles ld_valid one cycle before byte i.
  task automatic load(input int d, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [2:0] gaps, input bit mid_start);
    logic [7:0] bb;
    st[d] = 1'b1;
    tick();
    st[d] = 1'b0;
    chk("start_ready", int'(rdy[d]), 1);
    chk("start_loaded", int'(ld[d]), 0);
    for (int i = 0; i < 3; i++) begin
      bb = (i == 0) ? b0 : (i == 1) ? b1 : b2;
      if (gaps[i]) begin
        v[d] = 1'b0;
        tick();
        chk("gap_ready", int'(rdy[d]), 1);
      end
      v[d]   = 1'b1;
      dat[d] = bb;
      tick();
      v[d]   = 1'b0;
      if (i < 2) begin
        chk("mid_ready", int'(rdy[d]), 1);
        chk("mid_loaded", int'(ld[d]), 0);
      end else begin
        chk("end_ready", int'(rdy[d]), 0);
        chk("end_loaded", int'(ld[d]), 1);
      end
      if (i == 0 && mid_start) begin
        st[d] = 1'b1;
        tick();
        st[d] = 1'b0;
        chk("restart_ignored_ready", int'(rdy[d]), 1);
      end
    end
  endtask

  task automatic rd(input int d, input logic [15:0] a, input int exp, input string name);
    addr[d] = a;
    tick();
    chk(name, int'(q[d]), exp);
  endtask

  initial begin
    logic [7:0] rb0, rb1, rb2;
    int         a;

    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      st[d] = 1'b0; v[d] = 1'b0; dat[d] = '0; addr[d] = '0;
    end
    mov = 1'b0;

    vecs[0] = '{dut: 1'b0, gaps: 3'b000, b0: 8'h21, b1: 8'h43, b2: 8'h65,
                e: '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6}};
    vecs[1] = '{dut: 1'b1, gaps: 3'b000, b0: 8'hA7, b1: 8'hCB, b2: 8'hFE,
                e: '{4'h7, 4'hA, 4'hB, 4'hC, 4'hE, 4'h0}};
    vecs[2] = '{dut: 1'b0, gaps: 3'b111, b0: 8'h21, b1: 8'h43, b2: 8'h65,
                e: '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6}};
    vecs[3] = '{dut: 1'b0, gaps: 3'b101, b0: 8'h0F, b1: 8'hF0, b2: 8'h88,
                e: '{4'hF, 4'h0, 4'h0, 4'hF, 4'h8, 4'h8}};

    // Reset state
    tick();
    tick();
    chk("rst_ready", int'(rdy[0]), 0);
    chk("rst_loaded", int'(ld[0]), 0);
    chk("rst_data", int'(q[0]), 0);
    rst = 1'b1;
    rd(0, 16'h0000, 0, "post_rst_read0");
    chk("post_rst_loaded", int'(ld[0]), 0);
    chk("post_rst_ready", int'(rdy[0]), 0);

    // Table-driven loads; DEPTH=5 address 5 is out of range and must read 0
    for (int i = 0; i < 4; i++) begin
      load(int'(vecs[i].dut), vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].gaps, 1'b0);
      for (int k = 0; k < 6; k++) begin
        rd(int'(vecs[i].dut), 16'(k), int'($signed(vecs[i].e[k])), "table_read");
      end
    end

    // Randomized reloads against the image model
    for (int it = 0; it < 25; it++) begin
      rb0 = 8'($urandom);
      rb1 = 8'($urandom);
      rb2 = 8'($urandom);
      load(0, rb0, rb1, rb2, 3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0));
      mimg[0] = rb0[3:0]; mimg[1] = rb0[7:4];
      mimg[2] = rb1[3:0]; mimg[3] = rb1[7:4];
      mimg[4] = rb2[3:0]; mimg[5] = rb2[7:4];
      if ($urandom_range(0, 3) == 0) begin
        v[0]   = 1'b1;
        dat[0] = 8'($urandom);
        tick();
        v[0]   = 1'b0;
        mov    = 1'b1;
      end
      for (int k = 0; k < 6; k++) begin
        a = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 65535))
                                        : int'($urandom_range(0, 7));
        rd(0, 16'(a), (a < 6) ? int'(mimg[a]) : 0, "rand_read");
      end
      chk("rand_overflow", int'(ov[0]), int'(mov));
    end

    // Overflow then reload
    v[0]   = 1'b1;
    dat[0] = 8'h99;
    tick();
    v[0]   = 1'b0;
    chk("ovf_flag", int'(ov[0]), 1);
    chk("ovf_loaded", int'(ld[0]), 1);
    for (int k = 0; k < 6; k++) begin
      rd(0, 16'(k), int'(mimg[k]), "ovf_mem_unchanged");
    end
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    chk("reload_loaded", int'(ld[0]), 0);
    rd(0, 16'h0000, 0, "reload_read_zero");
    load(0, 8'h87, 8'h09, 8'h3C, 3'b010, 1'b0);
    rd(0, 16'h0000, 7, "reload_a0");
    rd(0, 16'h0001, -8, "reload_a1");
    rd(0, 16'h0002, -7, "reload_a2");
    rd(0, 16'h0003, 0, "reload_a3");
    rd(0, 16'h0004, -4, "reload_a4");
    rd(0, 16'h0005, 3, "reload_a5");
    chk("ovf_sticky", int'(ov[0]), 1);

    // Reset mid-load after one byte
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    v[0] = 1'b1;
    dat[0] = 8'h21;
    tick();
    v[0] = 1'b0;
    rst = 1'b0;
    #2;
    chk("async_rst_loaded", int'(ld[0]), 0);
    chk("async_rst_ready", int'(rdy[0]), 0);
    chk("async_rst_ovf", int'(ov[0]), 0);
    tick();
    rst = 1'b1;
    rd(0, 16'h0003, 0, "stale_unreachable");
    chk("idle_ready", int'(rdy[0]), 0);
    load(0, 8'hBA, 8'hDC, 8'h1E, 3'b000, 1'b0);
    rd(0, 16'h0000, -6, "rl_a0");
    rd(0, 16'h0001, -5, "rl_a1");
    rd(0, 16'h0002, -4, "rl_a2");
    rd(0, 16'h0003, -3, "rl_a3");
    rd(0, 16'h0004, -2, "rl_a4");
    rd(0, 16'h0005, 1, "rl_a5");
    rd(0, 16'hFFFF, 0, "oor_ffff");
    rd(0, 16'h0006, 0, "oor_depth");

    // Start and valid together in IDLE: the byte must not be written
    st[1]  = 1'b1;
    v[1]   = 1'b1;
    dat[1] = 8'h99;
    tick();
    st[1] = 1'b0;
    v[1]  = 1'b0;
    chk("idle_startvalid_ready", int'(rdy[1]), 1);
    chk("idle_startvalid_loaded", int'(ld[1]), 0);
    load(1, 8'h10, 8'h32, 8'h54, 3'b000, 1'b0);
    for (int k = 0; k < 6; k++) begin
      rd(1, 16'(k), (k < 5) ? k : 0, "d5_read");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dnn_param_mem.md
# dnn_param_mem

Parameter memory responder for the fixed-point sigmoid inference engines. It is the read-side partner of the engine's `mem_addr`/`mem_data` initiator port, storing activations, weights and both sigmoid LUTs as a flat nibble-addressed image. A byte-stream loader fills it before inference: each byte carries two nibbles, low nibble at the lower address. Once fully loaded, the block answers engine reads with fixed one-cycle latency.

## Interface
- `DATA_WIDTH`, 4: nibble width of one stored word and of `mem_data`.
- `ADDR_WIDTH`, 16: width of `mem_addr`.
- `DEPTH`, 16'h29de: number of stored words. Covers the image through the end of the L2 LUT at 16'h29ce+16.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `ld_start` input 1: single-cycle pulse that begins a (re)load of the whole image from address 0.
- `ld_valid` input 1: `ld_data` holds a valid byte.
- `ld_data` input 8: [3:0] goes to address a, [7:4] goes to address a+1.
- `ld_ready` output 1: block accepts a byte this cycle.
- `loaded` output 1: image complete; reads are served.
- `ld_overflow` output 1: sticky; a byte was offered with `ld_valid` after the load completed.
- `mem_addr` input ADDR_WIDTH: read address from the engine.
- `mem_data` output signed DATA_WIDTH: read data.

## Operation
- State machine states:
  - IDLE (reset state).
  - LOAD.
  - READY.
- IDLE: `ld_start` moves to LOAD and clears the write pointer `wp` to 0. Every other input is ignored.
- LOAD:
  - `ld_ready`=1.
  - On `ld_valid && ld_ready`:
    - write `ld_data[3:0]` to `mem[wp]`;
    - if wp+1 < DEPTH, write `ld_data[7:4]` to `mem[wp+1]`; otherwise discard the upper nibble (odd DEPTH);
    - set wp += 2.
  - The byte that makes wp+2 >= DEPTH is the last one. The state goes to READY on that same edge.
- READY:
  - `loaded`=1 and `ld_ready`=0.
  - `ld_valid`=1 in READY sets `ld_overflow`. The byte is dropped.
  - `ld_start` in READY returns to LOAD, clears `wp` and clears `loaded` (reload). `ld_overflow` stays set until reset.
- `ld_start` while in LOAD is ignored and does not restart the pointer.
- Read port:
  - every cycle, `mem_data` <= (`loaded` && `mem_addr` < DEPTH) ? `mem[mem_addr]` : 0;
  - reads outside READY always return 0;
  - out-of-range addresses return 0 without any error flag.
- Contents are not cleared by reset. After reset, stale contents are unreachable until a full load completes.
- Storage is a DEPTH x DATA_WIDTH array with two nibble writes per cycle. The read is a registered single port.

## Timing
- Reset values:
  - `ld_ready`=0, `loaded`=0, `ld_overflow`=0, `mem_data`=0;
  - state=IDLE, `wp`=0.
- Read latency is exactly 1 cycle: `mem_addr` sampled at edge N appears on `mem_data` after edge N and is stable for the whole of cycle N+1. This is the latency the engine FSM is built around. There is no stall.
- `ld_start` high at edge N (from IDLE or READY): `ld_ready`=1 from edge N. The first byte can be accepted at edge N+1.
- The last accepted byte at edge M gives `loaded`=1 and `ld_ready`=0 after edge M. A read of any address presented at edge M+1 returns loaded data after edge M+1.
- A full load of DEPTH words takes ceil(DEPTH/2) accepted bytes. With continuous `ld_valid` this is ceil(DEPTH/2) cycles after the start cycle.
- Back-pressure: `ld_ready` depends only on state, never combinationally on `ld_valid`.
- `rst` asserted mid-LOAD: the block goes to IDLE immediately and asynchronously, and the partial load is abandoned. A new `ld_start` is required.
- `ld_start` and `ld_valid` together in IDLE: only the start is taken; the byte is not written.

## Test plan
- Reset check, DEPTH=6: release `rst`, then read address 0. Required: `mem_data`=0, `loaded`=0, `ld_ready`=0.
- Basic load, DEPTH=6: pulse `ld_start`, then stream bytes 8'h21, 8'h43, 8'h65 back-to-back. Required: `loaded` rises right after the third byte. Reading addresses 0..5 returns 1,2,3,4,5,6, each one cycle after its address.
- Odd depth, DEPTH=5: bytes 8'hA7, 8'hCB, 8'hFE. Required: addresses 0..4 read 7, -6, -5, -4, -2 as signed values; nibble F is discarded; `loaded`=1 after the third byte.
- Gapped valid: toggle `ld_valid` every other cycle during the DEPTH=6 load. Required: the same image and `ld_ready` held at 1 until the third accepted byte.
- Overflow and reload:
  - one extra byte 8'h99 after `loaded` → `ld_overflow`=1 and memory unchanged;
  - then `ld_start` → `loaded`=0, reads return 0, and a new image loads correctly;
  - `ld_overflow` stays 1.
- Reset mid-load, plus read out of range:
  - assert `rst` after 1 of 3 bytes → `loaded`=0 and `ld_ready`=0 asynchronously;
  - a later full load succeeds;
  - `mem_addr`=16'hFFFF returns 0.
